// File: rtl/ppm_symbol_decoder.sv
// rtl/ppm_symbol_decoder.sv - 4-PPM frame/symbol decoder with start-flag detection and a 1-deep output register
//
// Purpose:
//   Watches a raw PPM line, one sample per sample_tick. A run of START_LEN
//   high samples arms the decoder. The first low sample after that starts a
//   frame of NSYM symbols. Each symbol is four slots, and the symbol value is
//   the index of the single high slot. Decoded symbols are presented through
//   a valid/ready output register.
//
// Parameters:
//   START_LEN  consecutive high samples forming the start flag (2..15)
//   NSYM       symbols per frame (1..255)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_tick  in   one-clk slot sampling strobe
//   ppm_in       in   raw PPM line, idle low
//   sym_ready    in   consumer accepts the held symbol
//   sym_valid    out  output register holds an unaccepted symbol
//   sym_data     out  slot index (0..3) of the pulse
//   sym_err      out  symbol had zero or several high slots
//   frame_done   out  one-clk pulse when the last symbol of a frame decodes
//   overrun      out  sticky, a decoded symbol was dropped
//
// Configuration:
//   PPM_IN_SYNC_EN  when defined, ppm_in passes through a 2-flop synchronizer
//                   before sampling (2 clk extra input latency)

module ppm_symbol_decoder #(
    parameter int START_LEN = 4,
    parameter int NSYM      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       ppm_in,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic [1:0] sym_data,
    output logic       sym_err,
    output logic       frame_done,
    output logic       overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [3:0] HI_LAST  = 4'(START_LEN - 1);
    localparam logic [7:0] SYM_LAST = 8'(NSYM - 1);

    logic [1:0] r_state;
    logic [3:0] r_hi_cnt;
    logic [1:0] r_slot_cnt;
    logic [7:0] r_sym_cnt;
    logic [3:0] r_mask;

    logic       w_sample;
    logic [3:0] w_mask_next;
    logic       w_complete;
    logic       w_last;
    logic [1:0] w_dec_data;
    logic       w_dec_err;

`ifdef PPM_IN_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ppm_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = ppm_in;
`endif

    // Mask including the slot being sampled this tick, so the completing
    // tick (slot 3) decodes all four slots without an extra cycle.
    assign w_mask_next = r_mask | ({3'b000, w_sample} << r_slot_cnt);
    assign w_complete  = sample_tick && (r_state == ST_DATA) && (r_slot_cnt == 2'd3);
    assign w_last      = w_complete && (r_sym_cnt == SYM_LAST);

    always_comb begin
        w_dec_data = 2'd0;
        w_dec_err  = 1'b0;
        case (w_mask_next)
            4'b0001: w_dec_data = 2'd0;
            4'b0010: w_dec_data = 2'd1;
            4'b0100: w_dec_data = 2'd2;
            4'b1000: w_dec_data = 2'd3;
            default: w_dec_err  = 1'b1;
        endcase
    end

    // Framing state advances only on sample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hi_cnt   <= 4'd0;
            r_slot_cnt <= 2'd0;
            r_sym_cnt  <= 8'd0;
            r_mask     <= 4'd0;
        end else if (sample_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sample) begin
                        if (r_hi_cnt == HI_LAST) begin
                            r_state  <= ST_ARM;
                            r_hi_cnt <= 4'd0;
                        end else begin
                            r_hi_cnt <= r_hi_cnt + 4'd1;
                        end
                    end else begin
                        r_hi_cnt <= 4'd0;
                    end
                end
                ST_ARM: begin
                    // A flag longer than START_LEN is tolerated here.
                    if (!w_sample) begin
                        r_state    <= ST_DATA;
                        r_slot_cnt <= 2'd0;
                        r_sym_cnt  <= 8'd0;
                        r_mask     <= 4'd0;
                    end
                end
                ST_DATA: begin
                    r_slot_cnt <= r_slot_cnt + 2'd1;
                    if (r_slot_cnt == 2'd3) begin
                        r_mask    <= 4'd0;
                        r_sym_cnt <= r_sym_cnt + 8'd1;
                        if (r_sym_cnt == SYM_LAST) begin
                            r_state   <= ST_IDLE;
                            r_hi_cnt  <= 4'd0;
                            r_sym_cnt <= 8'd0;
                        end
                    end else begin
                        r_mask <= w_mask_next;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hi_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Output register: a completing symbol loads if the register is empty or
    // being accepted this cycle; otherwise it is dropped and overrun sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid  <= 1'b0;
            sym_data   <= 2'd0;
            sym_err    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= w_last;
            if (w_complete) begin
                if (!sym_valid || sym_ready) begin
                    sym_valid <= 1'b1;
                    sym_data  <= w_dec_data;
                    sym_err   <= w_dec_err;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppm_symbol_decoder.sv
// tb/tb_ppm_symbol_decoder.sv - self-checking bench for ppm_symbol_decoder

module tb_ppm_symbol_decoder;

    localparam int START_LEN = 4;
    localparam int NSYM      = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_tick;
    logic       ppm_in;
    logic       sym_ready;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_err;
    logic       frame_done;
    logic       overrun;

    ppm_symbol_decoder #(
        .START_LEN (START_LEN),
        .NSYM      (NSYM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ppm_in      (ppm_in),
        .sym_ready   (sym_ready),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_err     (sym_err),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // One line sample per tick plus what the outputs must show right after it.
    typedef struct {
        logic       b;
        logic       v;
        logic [1:0] d;
        logic       e;
        logic       f;
    } step_t;

    step_t q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_step(input logic b, input logic v, input logic [1:0] d,
                             input logic e, input logic f);
        step_t s;
        s.b = b; s.v = v; s.d = d; s.e = e; s.f = f;
        q.push_back(s);
    endtask

    task automatic push_idle(input logic b);
        push_step(b, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push_flag(input int len);
        repeat (len) push_idle(1'b1);
        push_idle(1'b0);
    endtask

    // Reference rule: exactly one high slot -> its index, else data 0 with error.
    task automatic push_symbol(input logic [3:0] slots, input logic last);
        int         ones;
        logic [1:0] idx;
        ones = $countones(slots);
        idx  = 2'd0;
        for (int k = 0; k < 4; k++) if (slots[k]) idx = 2'(k);
        for (int k = 0; k < 3; k++) push_idle(slots[k]);
        push_step(slots[3], 1'b1, (ones == 1) ? idx : 2'd0, (ones != 1), last);
    endtask

    task automatic tick_edge(input logic b, input logic rdy);
        ppm_in = b;
        repeat (15) @(negedge clk);
        sample_tick = 1'b1;
        sym_ready   = rdy;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic run_queue(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            tick_edge(s.b, sym_ready);
            chk({tag, "_valid"}, 8'(sym_valid), 8'(s.v));
            if (s.v) begin
                chk({tag, "_data"}, 8'(sym_data), 8'(s.d));
                chk({tag, "_err"}, 8'(sym_err), 8'(s.e));
            end
            chk({tag, "_frame_done"}, 8'(frame_done), 8'(s.f));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 8'(sym_valid), 8'd0);
        chk({tag, "_data"}, 8'(sym_data), 8'd0);
        chk({tag, "_err"}, 8'(sym_err), 8'd0);
        chk({tag, "_frame_done"}, 8'(frame_done), 8'd0);
        chk({tag, "_overrun"}, 8'(overrun), 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] slots_a;
        logic [3:0] slots_b;
        logic [3:0] rs;

        rst_n       = 1'b0;
        sample_tick = 1'b0;
        ppm_in      = 1'b0;
        sym_ready   = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Basic frame: slot 2 then slot 0, frame_done with the second.
        push_flag(START_LEN);
        push_symbol(4'b0100, 1'b0);
        push_symbol(4'b0001, 1'b1);
        repeat (3) push_idle(1'b0);
        run_queue("basic");

        // Empty slot group and two-pulse group both decode as errors.
        push_flag(START_LEN);
        push_symbol(4'b0000, 1'b0);
        push_symbol(4'b0110, 1'b1);
        // Start-flag pattern inside a frame is just an error symbol.
        push_flag(START_LEN);
        push_symbol(4'b1111, 1'b0);
        push_symbol(4'b1111, 1'b1);
        push_idle(1'b0);
        run_queue("err");

        // Short flag does not arm; long flag does.
        push_idle(1'b1); push_idle(1'b1); push_idle(1'b1); push_idle(1'b0);
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b1); push_idle(1'b0);
        push_idle(1'b1); push_idle(1'b0); push_idle(1'b0); push_idle(1'b0);
        push_flag(START_LEN + 2);
        push_symbol(4'b1000, 1'b0);
        push_symbol(4'b0010, 1'b1);
        push_idle(1'b0);
        run_queue("flag");

        // Randomized frames with gaps and sub-threshold high runs between them.
        for (int f = 0; f < 12; f++) begin
            push_flag(START_LEN + int'($urandom_range(0, 2)));
            for (int s = 0; s < NSYM; s++) begin
                if ($urandom_range(0, 3) != 0) rs = 4'b0001 << $urandom_range(0, 3);
                else                           rs = 4'($urandom_range(0, 15));
                push_symbol(rs, (s == NSYM - 1));
            end
            repeat ($urandom_range(1, 3)) push_idle(1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat (START_LEN - 1) push_idle(1'b1);
                push_idle(1'b0);
            end
        end
        run_queue("rand");
        chk("rand_overrun", 8'(overrun), 8'd0);

        // Consumer stalls across two completions: first held, second dropped.
        slots_a = 4'b0100;
        slots_b = 4'b1000;
        repeat (START_LEN) tick_edge(1'b1, 1'b0);
        tick_edge(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick_edge(slots_a[k], 1'b0);
        chk("stall_first_valid", 8'(sym_valid), 8'd1);
        chk("stall_first_data", 8'(sym_data), 8'd2);
        chk("stall_first_overrun", 8'(overrun), 8'd0);
        for (int k = 0; k < 4; k++) tick_edge(slots_b[k], 1'b0);
        chk("stall_held_valid", 8'(sym_valid), 8'd1);
        chk("stall_held_data", 8'(sym_data), 8'd2);
        chk("stall_held_err", 8'(sym_err), 8'd0);
        chk("stall_overrun", 8'(overrun), 8'd1);
        chk("stall_frame_done", 8'(frame_done), 8'd1);
        repeat (3) @(negedge clk);
        chk("stall_hold_data", 8'(sym_data), 8'd2);
        sym_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_valid", 8'(sym_valid), 8'd0);
        chk("accept_overrun", 8'(overrun), 8'd1);
        @(posedge clk); #1;
        chk("idle_ready_valid", 8'(sym_valid), 8'd0);
        chk("idle_ready_overrun", 8'(overrun), 8'd1);

        // Reset clears overrun; accept and completion in the same cycle.
        do_reset();
        chk("rst2_overrun", 8'(overrun), 8'd0);
        repeat (START_LEN) tick_edge(1'b1, 1'b0);
        tick_edge(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick_edge(slots_a[k], 1'b0);
        for (int k = 0; k < 4; k++) tick_edge(slots_b[k], (k == 3));
        chk("simul_valid", 8'(sym_valid), 8'd1);
        chk("simul_data", 8'(sym_data), 8'd3);
        chk("simul_overrun", 8'(overrun), 8'd0);
        chk("simul_frame_done", 8'(frame_done), 8'd1);
        @(posedge clk); #1;
        chk("simul_clear_valid", 8'(sym_valid), 8'd0);
        chk("simul_clear_done", 8'(frame_done), 8'd0);

        // Reset in the middle of symbol 1 while symbol 0 is held.
        repeat (START_LEN) tick_edge(1'b1, 1'b0);
        tick_edge(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick_edge(slots_a[k], 1'b0);
        chk("midrst_pre_valid", 8'(sym_valid), 8'd1);
        tick_edge(1'b0, 1'b0);
        tick_edge(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        sym_ready = 1'b1;
        push_idle(1'b0);
        push_idle(1'b0);
        push_flag(START_LEN);
        push_symbol(4'b1000, 1'b0);
        push_symbol(4'b0010, 1'b1);
        push_idle(1'b0);
        run_queue("postrst");

        // Line edge 1 clk before a tick: seen directly, missed through the synchronizer.
        repeat (START_LEN - 1) tick_edge(1'b1, 1'b1);
        ppm_in = 1'b0;
        repeat (14) @(negedge clk);
        ppm_in = 1'b1;
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        chk("late_edge_valid", 8'(sym_valid), 8'd0);
`ifdef PPM_IN_SYNC_EN
        push_idle(1'b0);
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b1); push_idle(1'b0);
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b1); push_idle(1'b0);
`else
        push_idle(1'b0);
        push_symbol(4'b0100, 1'b0);
        push_symbol(4'b0100, 1'b1);
`endif
        push_idle(1'b0);
        run_queue("late_edge");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppm_symbol_decoder.md
PPM_SYMBOL_DECODER -- requirements
Module: ppm_symbol_decoder

Interface
REQ-001 Parameter START_LEN, default 4: consecutive high samples forming the frame start flag (range 2..15).
REQ-002 Parameter NSYM, default 8: symbols per frame (range 1..255).
REQ-003 Port clk  input  1  single system clock, all logic rising-edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port sample_tick  input  1  one-clk-wide strobe, 1 per 16 clk (divided sampling tick); one tick = one PPM slot sample.
REQ-006 Port ppm_in  input  1  raw PPM line, idle low.
REQ-007 Port sym_ready  input  1  consumer accepts symbol when high with sym_valid.
REQ-008 Port sym_valid  output  1  output register holds an unaccepted symbol.
REQ-009 Port sym_data  output  2  4-PPM slot index (0..3) of the pulse.
REQ-010 Port sym_err  output  1  symbol had zero or more than one high slot.
REQ-011 Port frame_done  output  1  one-clk pulse after final symbol of a frame is decoded.
REQ-012 Port overrun  output  1  sticky: a decoded symbol was dropped.

Function
REQ-013 ppm_in SHALL be sampled only in cycles where sample_tick=1; all state advances only on ticks, except handshake logic.
REQ-014 FSM states: IDLE, ARM, DATA.
REQ-015 IDLE: 4-bit hi_cnt increments on tick with sample 1, clears on tick with sample 0; tick with sample 1 and hi_cnt=START_LEN-1 -> ARM, hi_cnt cleared.
REQ-016 ARM: tick with sample 1 -> stay ARM (long flag tolerated); tick with sample 0 -> DATA, slot_cnt=0, sym_cnt=0.
REQ-017 DATA: each tick samples slot slot_cnt (0..3); 4-bit mask collects high slots; slot_cnt wraps 3->0 and sym_cnt increments at wrap.
REQ-018 Symbol complete on tick sampling slot 3: exactly one mask bit set -> data=its index, err=0; otherwise data=0, err=1.
REQ-019 Completed symbol SHALL appear on sym_data/sym_err with sym_valid=1 in the clk cycle after the completing tick (latency 1 clk).
REQ-020 sym_valid, sym_data, sym_err SHALL hold stable until a cycle with sym_valid=1 and sym_ready=1; sym_valid then clears next clk unless a new symbol loads in that same cycle.
REQ-021 Simultaneous accept and completion: new symbol loads, sym_valid stays 1, overrun unchanged.
REQ-022 Completion while sym_valid=1 and sym_ready=0: new symbol dropped, held symbol kept, overrun set to 1.
REQ-023 Completion of symbol sym_cnt=NSYM-1: FSM -> IDLE, hi_cnt=0, frame_done=1 for exactly one clk, coincident with that symbol's sym_valid rise or drop.
REQ-024 Pulses in DATA never restart framing; a start-flag pattern inside a frame decodes as error symbols.
REQ-025 sym_ready with sym_valid=0 SHALL have no effect.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, all counters and mask to 0, sym_valid=0, sym_data=0, sym_err=0, frame_done=0, overrun=0.
REQ-027 Reset mid-frame SHALL abandon the frame; no partial symbol emitted after release.
REQ-028 After release, first tick is treated as IDLE sample with hi_cnt=0.

Configuration
REQ-029 Macro PPM_IN_SYNC_EN defined: ppm_in passes through a 2-flop synchronizer (reset 0) before sampling; sampled value is the synchronizer output, adding 2 clk input latency.
REQ-030 Macro PPM_IN_SYNC_EN undefined: ppm_in sampled directly; no synchronizer flops.

Verification
REQ-031 START_LEN=4, NSYM=2, sym_ready=1: line 1,1,1,1,0 then slots 0,0,1,0 / 1,0,0,0 -> symbols (2,err0),(0,err0); frame_done with second; back in IDLE.
REQ-032 Start flag then slots 0,0,0,0 and 0,1,1,0 -> two symbols data=0, err=1 each.
REQ-033 sym_ready=0 across two completions -> first symbol held unchanged, overrun=1; sym_ready=1 then -> held symbol accepted, sym_valid clears, overrun stays 1.
REQ-034 Only 3 highs then 0 -> no ARM, no symbols; 6 highs then 0 -> frame starts (long flag).
REQ-035 rst_n pulsed low mid-symbol 1 -> all outputs 0 immediately; following valid frame decodes correctly.
REQ-036 With PPM_IN_SYNC_EN: ppm_in edge 1 clk before tick not sampled on that tick; without it, sampled.
